// File: rtl/fnd_display_ctrl.sv
// Basys3 4-digit common-anode 7-segment driver for the watch time bus.
// Scans one digit per tick; each frame is decoded from a single snapshot of the inputs.
module fnd_display_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_mode,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] counter;
  logic          tick;
  logic [1:0]    idx;

  logic          snap_mode;
  logic [6:0]    snap_msec;
  logic [5:0]    snap_sec;
  logic [5:0]    snap_min;
  logic [4:0]    snap_hour;

  logic [6:0]    field;
  logic          bad;
  logic [3:0]    quot;
  logic [3:0]    rem;
  logic [3:0]    digit;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    com_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick = (counter == LAST);

  // Odd idx shows the tens digit of a field, even idx the ones digit.
  always_comb begin
    field = '0;
    bad   = 1'b0;
    quot  = '0;
    rem   = '0;
    if (idx[1] == 1'b0) begin
      if (snap_mode) begin
        field = {1'b0, snap_min};
        bad   = (snap_min > 6'd59);
      end else begin
        field = snap_msec;
        bad   = (snap_msec > 7'd99);
      end
    end else begin
      if (snap_mode) begin
        field = {2'b00, snap_hour};
        bad   = (snap_hour > 5'd23);
      end else begin
        field = {1'b0, snap_sec};
        bad   = (snap_sec > 6'd59);
      end
    end
    for (int k = 1; k <= 12; k++) begin
      if (field >= 7'(k * 10)) quot = 4'(k);
    end
    rem      = field[3:0] - (quot * 4'd10);
    digit    = idx[0] ? quot : rem;
    seg      = bad ? 7'b0111111 : seg7(digit);
    dp_n     = !((idx == 2'd2) && (snap_msec < 7'd50));
    com_next = ~(4'b0001 << idx);
  end

  // Outputs and snapshot only move on a tick; the idx==3 tick still shows the old snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter   <= '0;
      idx       <= '0;
      snap_mode <= 1'b0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
      fnd_com   <= 4'b1111;
      fnd_data  <= 8'hFF;
    end else begin
      counter <= tick ? '0 : counter + 1'b1;
      if (tick) begin
        fnd_com  <= com_next;
        fnd_data <= {dp_n, seg};
        idx      <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap_mode <= sw_mode;
          snap_msec <= msec;
          snap_sec  <= sec;
          snap_min  <= min;
          snap_hour <= hour;
        end
      end
    end
  end

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// Directed bench for fnd_display_ctrl with SCAN_DIV=4; expected {com,data} values are hand-derived.
module tb_fnd_display_ctrl;

  logic       clk;
  logic       rst;
  logic       sw_mode;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int vectors;
  int miscompares;

  fnd_display_ctrl #(.CLK_FREQ(100), .SCAN_HZ(25)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_mode  (sw_mode),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic m, input logic [6:0] ms, input logic [5:0] s,
                               input logic [5:0] mi, input logic [4:0] h);
    sw_mode = m;
    msec    = ms;
    sec     = s;
    min     = mi;
    hour    = h;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got com/data %h, expected %h", tag, observed, expected);
    end
  endtask

  // One digit period is four clocks; sample 1 time unit after the updating edge.
  task automatic scanDigit(input string tag, input logic [11:0] expected);
    repeat (4) @(posedge clk);
    #1;
    checkOutput(tag, {fnd_com, fnd_data}, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    applyStimulus(1'b0, 7'd0, 6'd0, 6'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", {fnd_com, fnd_data}, 12'hFFF);

    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_tick", {fnd_com, fnd_data}, 12'hFFF);
    @(posedge clk);
    #1;
    checkOutput("f1_d0", {fnd_com, fnd_data}, 12'hEC0);
    applyStimulus(1'b0, 7'd37, 6'd42, 6'd0, 5'd0);
    scanDigit("f1_d1", 12'hDC0);
    scanDigit("f1_d2", 12'hB40);
    scanDigit("f1_d3", 12'h7C0);

    // Mode 0: 42.37 with dp on
    scanDigit("m0_d0", 12'hEF8);
    applyStimulus(1'b1, 7'd75, 6'd0, 6'd5, 5'd23);
    scanDigit("m0_d1", 12'hDB0);
    scanDigit("m0_d2", 12'hB24);
    scanDigit("m0_d3", 12'h799);

    // Mode 1: 23.05 with dp off
    scanDigit("m1_d0", 12'hE92);
    applyStimulus(1'b0, 7'd80, 6'd60, 6'd0, 5'd0);
    scanDigit("m1_d1", 12'hDC0);
    scanDigit("m1_d2", 12'hBB0);
    scanDigit("m1_d3", 12'h7A4);

    // sec out of range -> dashes, msec=80 unaffected
    scanDigit("rng_d0", 12'hEC0);
    applyStimulus(1'b0, 7'd37, 6'd42, 6'd0, 5'd0);
    scanDigit("rng_d1", 12'hD80);
    scanDigit("rng_d2", 12'hBBF);
    scanDigit("rng_d3", 12'h7BF);

    // Coherence: change mid-frame at idx==1
    scanDigit("coh_d0", 12'hEF8);
    applyStimulus(1'b1, 7'd37, 6'd17, 6'd34, 5'd12);
    scanDigit("coh_d1", 12'hDB0);
    scanDigit("coh_d2", 12'hB24);
    scanDigit("coh_d3", 12'h799);
    scanDigit("new_d0", 12'hE99);
    scanDigit("new_d1", 12'hDB0);

    // Async reset with idx==2
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_rst", {fnd_com, fnd_data}, 12'hFFF);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pre_tick", {fnd_com, fnd_data}, 12'hFFF);
    @(posedge clk);
    #1;
    checkOutput("rst_d0", {fnd_com, fnd_data}, 12'hEC0);
    scanDigit("rst_d1", 12'hDC0);
    scanDigit("rst_d2", 12'hB40);
    scanDigit("rst_d3", 12'h7C0);
    scanDigit("post_d0", 12'hE99);
    scanDigit("post_d1", 12'hDB0);
    scanDigit("post_d2", 12'hB24);
    scanDigit("post_d3", 12'h7F9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
